// File: rtl/utils_top.sv
// Shared LSU definitions: funct3 encodings, opcodes, FSM state type.
package utils_top;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } lsu_state_t;

  function automatic logic addr_mis(input logic [1:0] sz,
                                    input logic [1:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return |a;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// Byte-lane steering for stores and lane extract/extend for loads.
module mem_access_lsu_align
  import utils_top::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_src,
  input  logic [31:0] ld_word,
  output logic [31:0] st_dat,
  output logic [3:0]  st_be,
  output logic [31:0] ld_val
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        sx;

  always_comb begin
    ld_b   = ld_word[{addr_lo, 3'b000} +: 8];
    ld_h   = ld_word[{addr_lo[1], 4'b0000} +: 16];
    sx     = 1'b0;
    st_dat = st_src;
    st_be  = 4'b1111;
    ld_val = ld_word;
    case (f3[1:0])
      2'b00: begin
        sx     = ~f3[2] & ld_b[7];
        st_dat = {4{st_src[7:0]}};
        st_be  = 4'b0001 << addr_lo;
        ld_val = {{24{sx}}, ld_b};
      end
      2'b01: begin
        sx     = ~f3[2] & ld_h[15];
        st_dat = {2{st_src[15:0]}};
        st_be  = 4'b0011 << {addr_lo[1], 1'b0};
        ld_val = {{16{sx}}, ld_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_lsu.sv
// Load/store stage between execute and writeback with req/gnt/rvalid
// memory handshake, timeout and registered writeback/forward outputs.
module mem_access_lsu
  import utils_top::*;
#(
  parameter int unsigned MAIN_MEM_BYTE_ADD_W = 8,
  parameter int unsigned MEM_TIMEOUT_CYC     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_vld,
  output logic        ex_rdy,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_dat,
  input  logic [31:0] ex_rd2,
  output logic        wb_vld,
  output logic [31:0] wb_dat,
  output logic [31:0] wb_inst,
  output logic [31:0] wb_pc,
  output logic        id_fwd_we,
  output logic [4:0]  id_fwd_dst,
  output logic [31:0] id_fwd_dat,
  output logic        exc_main_addr_mis,
  output logic        exc_main_addr_oob,
  output logic        exc_main_timeout,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_wen,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dat_in,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_dat_out
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT_CYC - 1);

  lsu_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d, pc_q, pc_d;
  logic [31:0] dat_q, dat_d, rd2_q, rd2_d;
  logic        wb_vld_q, wb_vld_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [31:0] wb_inst_q, wb_inst_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic        mis_q, mis_d, oob_q, oob_d, to_q, to_d;
  logic        fwd_we_q, fwd_we_d;

  logic        ex_mem, ex_jmp, ex_mis, ex_oob, cap_st, last;
  logic [31:0] al_st, al_ld;
  logic [3:0]  al_be;

  mem_access_lsu_align u_align (
    .f3      (inst_q[14:12]),
    .addr_lo (dat_q[1:0]),
    .st_src  (rd2_q),
    .ld_word (mem_dat_out),
    .st_dat  (al_st),
    .st_be   (al_be),
    .ld_val  (al_ld)
  );

  assign ex_mem = ex_inst[6:0] == OP_LOAD || ex_inst[6:0] == OP_STORE;
  assign ex_jmp = ex_inst[6:0] == OP_JAL || ex_inst[6:0] == OP_JALR;
  assign ex_mis = addr_mis(ex_inst[13:12], ex_dat[1:0]);
  assign ex_oob = (ex_dat >> MAIN_MEM_BYTE_ADD_W) != '0;
  assign cap_st = inst_q[6:0] == OP_STORE;
  assign last   = cnt_q == CNT_LAST;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    dat_d     = dat_q;
    rd2_d     = rd2_q;
    wb_vld_d  = 1'b0;
    wb_dat_d  = wb_dat_q;
    wb_inst_d = wb_inst_q;
    wb_pc_d   = wb_pc_q;
    mis_d     = 1'b0;
    oob_d     = 1'b0;
    to_d      = 1'b0;
    unique case (state_q)
      IDLE: if (ex_vld) begin
        inst_d = ex_inst;
        pc_d   = ex_pc;
        dat_d  = ex_dat;
        rd2_d  = ex_rd2;
        if (ex_mem && !ex_mis && !ex_oob) begin
          state_d = REQ;
          cnt_d   = '0;
        end else begin
          wb_vld_d  = 1'b1;
          wb_inst_d = ex_inst;
          wb_pc_d   = ex_pc;
          wb_dat_d  = ex_jmp ? ex_pc + 32'd4 : ex_dat;
          if (ex_mem) begin
            wb_dat_d = '0;
            mis_d    = ex_mis;
            oob_d    = ex_oob;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt) begin
          state_d = cap_st ? IDLE : WAIT_RSP;
          wb_vld_d = cap_st;
          if (cap_st) wb_dat_d = dat_q;
        end else if (last) begin
          state_d  = IDLE;
          wb_vld_d = 1'b1;
          wb_dat_d = '0;
          to_d     = 1'b1;
        end
        if (wb_vld_d) begin
          wb_inst_d = inst_q;
          wb_pc_d   = pc_q;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid || last) begin
          state_d   = IDLE;
          wb_vld_d  = 1'b1;
          wb_inst_d = inst_q;
          wb_pc_d   = pc_q;
          wb_dat_d  = mem_rvalid ? al_ld : '0;
          to_d      = ~mem_rvalid;
        end
      end
      default: state_d = IDLE;
    endcase
    fwd_we_d = wb_vld_d
             & (wb_inst_d[6:0] != OP_STORE)
             & (wb_inst_d[6:0] != OP_BRANCH)
             & ~(mis_d | oob_d | to_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      inst_q    <= '0;
      pc_q      <= '0;
      dat_q     <= '0;
      rd2_q     <= '0;
      wb_vld_q  <= 1'b0;
      wb_dat_q  <= '0;
      wb_inst_q <= '0;
      wb_pc_q   <= '0;
      mis_q     <= 1'b0;
      oob_q     <= 1'b0;
      to_q      <= 1'b0;
      fwd_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      dat_q     <= dat_d;
      rd2_q     <= rd2_d;
      wb_vld_q  <= wb_vld_d;
      wb_dat_q  <= wb_dat_d;
      wb_inst_q <= wb_inst_d;
      wb_pc_q   <= wb_pc_d;
      mis_q     <= mis_d;
      oob_q     <= oob_d;
      to_q      <= to_d;
      fwd_we_q  <= fwd_we_d;
    end
  end

  assign ex_rdy     = state_q == IDLE;
  assign mem_req    = state_q == REQ;
  assign mem_wen    = mem_req & cap_st;
  assign mem_be     = mem_req ? (cap_st ? al_be : 4'b1111) : 4'b0000;
  assign mem_addr   = mem_req ? {dat_q[31:2], 2'b00} : '0;
  assign mem_dat_in = mem_wen ? al_st : '0;

  assign wb_vld            = wb_vld_q;
  assign wb_dat            = wb_dat_q;
  assign wb_inst           = wb_inst_q;
  assign wb_pc             = wb_pc_q;
  assign id_fwd_we         = fwd_we_q;
  assign id_fwd_dst        = wb_inst_q[11:7];
  assign id_fwd_dat        = wb_dat_q;
  assign exc_main_addr_mis = mis_q;
  assign exc_main_addr_oob = oob_q;
  assign exc_main_timeout  = to_q;

endmodule

// File: tb/tb_mem_access_lsu.sv
// Randomized bench for mem_access_lsu against a byte-array memory model.
module tb_mem_access_lsu;

  localparam int T  = 16;
  localparam int AW = 8;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_vld = 1'b0;
  logic        ex_rdy;
  logic [31:0] ex_pc = '0, ex_inst = '0, ex_dat = '0, ex_rd2 = '0;
  logic        wb_vld;
  logic [31:0] wb_dat, wb_inst, wb_pc;
  logic        id_fwd_we;
  logic [4:0]  id_fwd_dst;
  logic [31:0] id_fwd_dat;
  logic        exc_mis, exc_oob, exc_to;
  logic        mem_req, mem_wen;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_dat_in;
  logic [31:0] mem_dat_out = '0;

  logic [7:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;

  mem_access_lsu #(
    .MAIN_MEM_BYTE_ADD_W (AW),
    .MEM_TIMEOUT_CYC     (T)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_vld            (ex_vld),
    .ex_rdy            (ex_rdy),
    .ex_pc             (ex_pc),
    .ex_inst           (ex_inst),
    .ex_dat            (ex_dat),
    .ex_rd2            (ex_rd2),
    .wb_vld            (wb_vld),
    .wb_dat            (wb_dat),
    .wb_inst           (wb_inst),
    .wb_pc             (wb_pc),
    .id_fwd_we         (id_fwd_we),
    .id_fwd_dst        (id_fwd_dst),
    .id_fwd_dat        (id_fwd_dat),
    .exc_main_addr_mis (exc_mis),
    .exc_main_addr_oob (exc_oob),
    .exc_main_timeout  (exc_to),
    .mem_req           (mem_req),
    .mem_gnt           (mem_gnt),
    .mem_wen           (mem_wen),
    .mem_be            (mem_be),
    .mem_addr          (mem_addr),
    .mem_dat_in        (mem_dat_in),
    .mem_rvalid        (mem_rvalid),
    .mem_dat_out       (mem_dat_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] w;
    w = {a[7:2], 2'b00};
    return {mem[w + 8'd3], mem[w + 8'd2], mem[w + 8'd1], mem[w]};
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rdy"}, ex_rdy, 1);
    chk({tag, "_wbv"}, wb_vld, 0);
    chk({tag, "_wbd"}, wb_dat, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_be"}, mem_be, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_exc"}, {exc_mis, exc_oob, exc_to, id_fwd_we}, 0);
  endtask

  // g: cycle index in REQ at which gnt is given; d: WAIT_RSP cycles before rvalid
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rd2,
                        input int g, input int d);
    logic [31:0] inst, pc, exp_dat, v, exp_st;
    logic [3:0]  exp_be;
    bit is_ld, is_st, mis, oob, to, done, in_req, fwd;
    int sz, r;
    inst = $urandom();
    inst[6:0] = op;
    inst[14:12] = f3;
    pc = $urandom() & 32'hFFFF_FFFC;
    is_ld = op == OP_LD;
    is_st = op == OP_ST;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis = (is_ld || is_st) && (addr % sz != 0);
    oob = (is_ld || is_st) && (addr >= 256);
    to = 0;
    exp_dat = (op == OP_JAL || op == OP_JR) ? pc + 4 : addr;
    exp_be = 4'((1 << sz) - 1) << (addr % 4);
    exp_st = sz == 1 ? {24'd0, rd2[7:0]} * 32'h0101_0101 :
             sz == 2 ? {16'd0, rd2[15:0]} * 32'h0001_0001 : rd2;
    chk("ex_rdy_idle", ex_rdy, 1);
    ex_vld = 1'b1;
    ex_inst = inst;
    ex_pc = pc;
    ex_dat = addr;
    ex_rd2 = rd2;
    @(posedge clk); #1;
    ex_vld = 1'b0;
    ex_dat = $urandom();
    ex_rd2 = $urandom();
    if ((is_ld || is_st) && !mis && !oob) begin
      r = g + 1 + d;
      done = 0;
      for (int k = 0; !done; k++) begin
        in_req = k <= g;
        chk("mem_req", mem_req, in_req);
        chk("ex_rdy_busy", ex_rdy, 0);
        chk("wb_quiet", wb_vld, 0);
        if (in_req) begin
          chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
          chk("mem_wen", mem_wen, is_st);
          chk("mem_be", mem_be, is_st ? exp_be : 4'hF);
          if (is_st) chk("mem_dat_in", mem_dat_in, exp_st);
        end
        mem_gnt = in_req && k == g;
        mem_rvalid = in_req ? ($urandom_range(0, 1) == 1) : (k == r);
        mem_dat_out = mem_rvalid && !in_req ? word_at(addr) : $urandom();
        if (mem_gnt && is_st) begin
          done = 1;
          for (int i = 0; i < sz; i++) mem[addr[7:0] + 8'(i)] = rd2[8*i +: 8];
        end else if (!in_req && k == r) begin
          done = 1;
          v = {mem[addr[7:0] + 8'd3], mem[addr[7:0] + 8'd2],
               mem[addr[7:0] + 8'd1], mem[addr[7:0]]};
          if (sz == 1) exp_dat = f3[2] ? {24'd0, v[7:0]} : 32'($signed(v[7:0]));
          else if (sz == 2) exp_dat = f3[2] ? {16'd0, v[15:0]} : 32'($signed(v[15:0]));
          else exp_dat = v;
        end else if (k == T - 1) begin
          done = 1;
          to = 1;
        end
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
      end
    end
    if (mis || oob || to) exp_dat = 0;
    fwd = !is_st && op != OP_BR && !(mis || oob || to);
    chk("wb_vld", wb_vld, 1);
    chk("wb_dat", wb_dat, exp_dat);
    chk("wb_inst", wb_inst, inst);
    chk("wb_pc", wb_pc, pc);
    chk("exc_mis", exc_mis, mis);
    chk("exc_oob", exc_oob, oob);
    chk("exc_to", exc_to, to);
    chk("fwd_we", id_fwd_we, fwd);
    chk("fwd_dst", id_fwd_dst, inst[11:7]);
    chk("fwd_dat", id_fwd_dat, exp_dat);
    if (to) chk("req_drop", mem_req, 0);
  endtask

  logic [6:0] ops [8];
  logic [6:0] op;
  logic [2:0] f3;
  logic [31:0] a;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom());
    ops = '{OP_ALU, OP_IMM, OP_JAL, OP_JR, OP_BR, OP_LD, OP_ST, OP_LD};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle_outputs("reset");

    run_op(OP_ALU, 3'b000, 32'h1234, 32'h0, 0, 0);
    run_op(OP_ALU, 3'b000, 32'h5678, 32'h0, 0, 0);
    {mem[3], mem[2], mem[1], mem[0]} = 32'h80AA_5511;
    run_op(OP_LD, 3'b000, 32'h03, 32'h0, 0, 2);
    run_op(OP_LD, 3'b100, 32'h03, 32'h0, 0, 2);
    run_op(OP_ST, 3'b001, 32'h06, 32'hBEEF, 3, 0);
    run_op(OP_LD, 3'b010, 32'h04, 32'h0, 1, 1);
    run_op(OP_LD, 3'b010, 32'h02, 32'h0, 0, 0);
    run_op(OP_LD, 3'b010, 32'h100, 32'h0, 0, 0);
    run_op(OP_ST, 3'b001, 32'h101, 32'h0, 0, 0);
    run_op(OP_LD, 3'b010, 32'h08, 32'h0, 1000, 0);
    run_op(OP_LD, 3'b001, 32'h0A, 32'h0, 5, 20);
    run_op(OP_ST, 3'b000, 32'h09, 32'h77, T - 1, 0);
    run_op(OP_JAL, 3'b000, 32'hDEAD_0000, 32'h0, 0, 0);

    // drop an outstanding load with reset, then offer a stale rvalid
    ex_inst = {25'd0, OP_LD};
    ex_dat = 32'h10;
    ex_vld = 1'b1;
    @(posedge clk); #1;
    ex_vld = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_dat_out = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_idle_outputs("rst_flight");
      @(posedge clk); #1;
    end

    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == OP_ST) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom());
      case ($urandom_range(0, 9))
        0: a = 32'($urandom_range(256, 4095));
        1: a = $urandom() | 32'h8000_0000;
        default: a = 32'($urandom_range(0, 255));
      endcase
      if (op != OP_LD && op != OP_ST) a = $urandom();
      if ($urandom_range(0, 7) == 0)
        run_op(op, f3, a, $urandom(), $urandom_range(8, 20), $urandom_range(0, 12));
      else
        run_op(op, f3, a, $urandom(), $urandom_range(0, 5), $urandom_range(0, 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
